// File: rtl/hapara_icap_feeder_pkg.sv
// Shared constants for the ICAP burst feeder: FSM state encoding and default sizes.
package hapara_icap_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_LEN_WIDTH  = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/hapara_icap_sync_fifo.sv
// Synchronous word buffer with a registered read port and full/empty flags.
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own.
module hapara_icap_sync_fifo
  import hapara_icap_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_data;
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees a slot, so a full buffer can still take a word.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_data   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hapara_icap_burst_feeder.sv
// Feeds a counted burst of bitstream words from a valid/ready stream into an
// ICAP-writer port (en/we/addr/din), with abort and done/aborted reporting.
module hapara_icap_burst_feeder
  import hapara_icap_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_start,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_abort,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    en,
  output logic [DATA_WIDTH/8-1:0] we,
  output logic [DATA_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_acc;
  logic [LEN_WIDTH-1:0]  r_wr;
  logic [DATA_WIDTH-1:0] r_next_addr;
  logic [DATA_WIDTH-1:0] r_addr;
  logic                  r_en;
  logic                  r_abt;
  logic                  r_done;
  logic                  r_aborted;

  logic                  w_active;
  logic                  w_abort;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_abort  = cmd_abort & w_active;
  assign s_ready  = (r_state == ST_RUN) & ~w_full & (r_acc < r_len);
  // Abort outranks any transfer in the same cycle.
  assign w_push   = s_valid & s_ready & ~w_abort;
  assign w_pop    = w_active & ~w_empty & ~w_abort;

  assign en      = r_en;
  assign we      = {BYTES{r_en}};
  assign addr    = r_addr;
  assign din     = w_fifo_data;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign aborted = r_aborted;

  hapara_icap_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_abort),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // DONE is entered on the edge that pops the last word, so the state's single
  // cycle overlaps that word's en cycle and the registered done lands right after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_acc   <= '0;
      r_wr    <= '0;
      r_abt   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_len   <= cmd_len;
            r_acc   <= '0;
            r_wr    <= '0;
            r_abt   <= 1'b0;
            r_state <= (cmd_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_abt   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_push && (r_acc + LEN_WIDTH'(1) == r_len)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_abort) begin
            r_abt   <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_pop && (r_wr + LEN_WIDTH'(1) == r_len)) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_push) begin
        r_acc <= r_acc + LEN_WIDTH'(1);
      end
      if (w_pop) begin
        r_wr <= r_wr + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en        <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_en      <= w_pop;
      r_done    <= (r_state == ST_DONE);
      r_aborted <= (r_state == ST_DONE) & r_abt;
      if ((r_state == ST_IDLE) && cmd_start) begin
        r_next_addr <= '0;
      end else if (w_pop) begin
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + DATA_WIDTH'(BYTES);
      end
    end
  end

endmodule

// File: doc/hapara_icap_burst_feeder.md
HAPARA_ICAP_BURST_FEEDER -- requirements
Module: hapara_icap_burst_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the bitstream word and address width.
REQ-002 Parameter FIFO_DEPTH, default 16, power of two, SHALL set the internal word-buffer depth.
REQ-003 Parameter LEN_WIDTH, default 24, SHALL set the word-count width.
REQ-004 clk  input  1  SHALL be the single clock; all logic rising-edge.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-006 cmd_start  input  1  SHALL request a burst; sampled only in IDLE.
REQ-007 cmd_len  input  LEN_WIDTH  SHALL give the burst word count; latched with cmd_start.
REQ-008 cmd_abort  input  1  SHALL terminate the current burst.
REQ-009 s_data  input  DATA_WIDTH  SHALL carry the bitstream word.
REQ-010 s_valid  input  1  SHALL mark s_data valid.
REQ-011 s_ready  output  1  SHALL indicate the block accepts s_data this cycle.
REQ-012 en  output  1  SHALL be the downstream ICAP-writer port enable.
REQ-013 we  output  DATA_WIDTH/8  SHALL be the byte write enables; all-ones when writing, else zero.
REQ-014 addr  output  DATA_WIDTH  SHALL be the byte address of the current word.
REQ-015 din  output  DATA_WIDTH  SHALL be the word presented downstream, unswapped.
REQ-016 busy  output  1  SHALL be high outside IDLE.
REQ-017 done  output  1  SHALL pulse one cycle at burst end.
REQ-018 aborted  output  1  SHALL pulse with done when the end was caused by cmd_abort.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE -> RUN on cmd_start with cmd_len != 0; IDLE -> DONE on cmd_start with cmd_len == 0.
REQ-021 A stream word SHALL be accepted when s_valid & s_ready; s_ready = (state == RUN) & FIFO not full & accepted count < cmd_len.
REQ-022 RUN -> DRAIN when accepted count reaches cmd_len.
REQ-023 Each cycle the FIFO is non-empty in RUN or DRAIN, one word SHALL be popped and driven with en=1, we=all-ones on the next cycle (registered outputs; min latency acceptance -> en = 2 cycles).
REQ-024 FIFO empty in RUN SHALL give en=0, we=0 (gap); no padding words inserted.
REQ-025 addr SHALL be 0 for the first written word and increment by DATA_WIDTH/8 per written word, wrapping modulo 2^DATA_WIDTH.
REQ-026 DRAIN -> DONE after the last word's en cycle; written count SHALL equal cmd_len exactly.
REQ-027 DONE SHALL assert done for one cycle and return to IDLE next cycle.
REQ-028 cmd_abort in RUN or DRAIN SHALL flush the FIFO, force en=0/we=0 next cycle, and enter DONE with aborted=1; abort outranks a simultaneous push/pop.
REQ-029 cmd_start outside IDLE SHALL be ignored; cmd_abort in IDLE or DONE SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL keep FIFO occupancy unchanged, including when full.

Reset
REQ-031 rst low SHALL force IDLE, empty FIFO, counters 0, and s_ready, en, we, addr, din, busy, done, aborted all 0, including mid-burst.

Structure
REQ-032 Shared package hapara_icap_feeder_pkg SHALL hold the state encoding and default width/depth constants.
REQ-033 The buffer SHALL be one sub-module hapara_icap_sync_fifo (synchronous, registered output, full/empty flags).

Verification
REQ-034 cmd_len=4, words 0xAA995566,0x20000000,0x30008001,0x0000000D back-to-back -> en high 4 consecutive cycles, addr 0,4,8,12, din in order, done one cycle later.
REQ-035 cmd_len=3, s_valid low for 5 cycles after word 1 -> en gap of matching length, addr continues 4,8, exactly 3 writes.
REQ-036 cmd_len=20, s_valid held high, FIFO_DEPTH=16 -> s_ready drops only at cmd_len, never overflow, 20 writes total.
REQ-037 cmd_len=10, cmd_abort after 5 accepted -> en=0 next cycle, done=aborted=1 one cycle, busy low after.
REQ-038 cmd_len=0 -> done pulse 2 cycles after cmd_start, en never high.
REQ-039 rst low mid-burst (cmd_len=8, 3 written) -> all outputs 0 next cycle; new cmd_start after release restarts addr at 0.
